// File: rtl/fpga_cfg_loader.sv
// Configuration loader: streams USB FIFO bytes into an FPGA slave port.
// Slave-serial (BUS_WIDTH=1) or SelectMAP (BUS_WIDTH=8) with supervision.
module fpga_cfg_loader #(
    parameter int BUS_WIDTH    = 8,
    parameter int CCLK_DIV     = 2,
    parameter int PROG_CYCLES  = 64,
    parameter int INIT_TIMEOUT = 65535,
    parameter int RD_HOLD      = 3,
    parameter int STARTUP_CLKS = 8,
    parameter int CNT_W        = 24
) (
    input  logic                 CK50,
    input  logic                 nRST,
    input  logic                 nPROG_REQ,
    input  logic                 nRXF,
    input  logic [7:0]           USB_D,
    output logic                 nRD,
    output logic                 PROG_B,
    input  logic                 INIT_B,
    input  logic                 DONE,
    output logic                 CCLK,
    output logic                 CSI_B,
    output logic                 RDWR_B,
    output logic [BUS_WIDTH-1:0] D,
    output logic                 nDONELED,
    output logic                 nERRLED,
    output logic [2:0]           STATE,
    output logic [CNT_W-1:0]     BYTES
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PROG  = 4'd1,
        S_WINIT = 4'd2,
        S_WDATA = 4'd3,
        S_READ  = 4'd4,
        S_SHIFT = 4'd5,
        S_START = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    localparam int            PW       = (CCLK_DIV > 1) ? $clog2(CCLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CCLK_DIV - 1);
    localparam logic [2:0]    LAST_BIT = (BUS_WIDTH == 1) ? 3'd7 : 3'd0;

    logic [1:0]           r_req_s;
    logic                 r_req_q;
    logic [1:0]           r_rxf_s;
    logic [1:0]           r_init_s;
    logic [1:0]           r_done_s;
    logic [PW-1:0]        r_pre;
    state_t               r_st;
    state_t               w_st_n;
    logic [31:0]          r_cnt;
    logic [31:0]          w_cnt_n;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_n;
    logic [7:0]           r_sr;
    logic [7:0]           w_sr_n;
    logic                 r_cclk;
    logic                 w_cclk_n;
    logic [CNT_W-1:0]     r_bytes;
    logic [CNT_W-1:0]     w_bytes_n;
    logic                 w_tick;
    logic                 w_reload;
    logic                 w_crc;
    logic                 w_init;
    logic                 w_done;
    logic                 w_rxf;
    logic [BUS_WIDTH-1:0] w_d;

    assign w_tick   = (r_pre == PRE_MAX);
    assign w_reload = r_req_q & ~r_req_s[1];
    assign w_init   = r_init_s[1];
    assign w_done   = r_done_s[1];
    assign w_rxf    = r_rxf_s[1];
    assign w_crc    = ~w_init &
                      ((r_st == S_WDATA) | (r_st == S_READ) | (r_st == S_SHIFT));

    always_ff @(posedge CK50) begin
        if (!nRST) begin
            r_req_s  <= 2'b11;
            r_req_q  <= 1'b1;
            r_rxf_s  <= 2'b11;
            r_init_s <= 2'b00;
            r_done_s <= 2'b00;
            r_pre    <= '0;
        end else begin
            r_req_s  <= {r_req_s[0], nPROG_REQ};
            r_req_q  <= r_req_s[1];
            r_rxf_s  <= {r_rxf_s[0], nRXF};
            r_init_s <= {r_init_s[0], INIT_B};
            r_done_s <= {r_done_s[0], DONE};
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge CK50) begin
        if (!nRST) begin
            r_st    <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sr    <= '0;
            r_cclk  <= 1'b0;
            r_bytes <= '0;
        end else begin
            r_st    <= w_st_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_sr    <= w_sr_n;
            r_cclk  <= w_cclk_n;
            r_bytes <= w_bytes_n;
        end
    end

    always_comb begin
        w_st_n    = r_st;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_sr_n    = r_sr;
        w_cclk_n  = r_cclk;
        w_bytes_n = r_bytes;
        if (w_reload) begin
            // a partial byte is dropped and never counted
            w_st_n    = S_PROG;
            w_cnt_n   = '0;
            w_cclk_n  = 1'b0;
            w_bytes_n = '0;
        end else if (w_crc) begin
            w_st_n   = S_ERR;
            w_cclk_n = 1'b0;
        end else begin
            unique case (r_st)
                S_PROG: begin
                    w_bytes_n = '0;
                    w_cnt_n   = r_cnt + 32'd1;
                    if (r_cnt == 32'(PROG_CYCLES - 1)) begin
                        w_st_n  = S_WINIT;
                        w_cnt_n = '0;
                    end
                end
                S_WINIT: begin
                    w_cnt_n = r_cnt + 32'd1;
                    if (w_init) begin
                        w_st_n = S_WDATA;
                    end else if (r_cnt == 32'(INIT_TIMEOUT - 1)) begin
                        w_st_n = S_ERR;
                    end
                end
                S_WDATA: begin
                    if (w_done) begin
                        w_st_n  = S_START;
                        w_cnt_n = '0;
                    end else if (!w_rxf && w_tick) begin
                        w_st_n  = S_READ;
                        w_cnt_n = '0;
                    end
                end
                S_READ: begin
                    if (r_cnt < 32'(RD_HOLD - 1)) begin
                        w_cnt_n = r_cnt + 32'd1;
                    end else if (w_tick) begin
                        w_sr_n  = USB_D;
                        w_bit_n = '0;
                        w_st_n  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        if (!r_cclk) begin
                            w_cclk_n = 1'b1;
                        end else begin
                            // data advances only on the falling edge
                            w_cclk_n = 1'b0;
                            if (r_bit == LAST_BIT) begin
                                w_st_n    = S_WDATA;
                                w_bytes_n = (&r_bytes) ? r_bytes : r_bytes + 1'b1;
                            end else begin
                                w_bit_n = r_bit + 3'd1;
                                w_sr_n  = {r_sr[6:0], 1'b0};
                            end
                        end
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!r_cclk) begin
                            w_cclk_n = 1'b1;
                        end else begin
                            w_cclk_n = 1'b0;
                            w_cnt_n  = r_cnt + 32'd1;
                            if (r_cnt == 32'(STARTUP_CLKS - 1)) begin
                                w_st_n = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!w_done && !w_init) begin
                        w_st_n = S_ERR;
                    end
                end
                S_IDLE, S_ERR: begin
                end
                default: begin
                    w_st_n = S_IDLE;
                end
            endcase
        end
    end

    if (BUS_WIDTH == 1) begin : g_ser
        assign w_d = r_sr[7];
    end else begin : g_par
        assign w_d = r_sr[BUS_WIDTH-1:0];
    end

    assign nRD      = (r_st != S_READ);
    assign PROG_B   = (r_st != S_PROG);
    assign CCLK     = r_cclk;
    assign CSI_B    = ~((r_st == S_WDATA) | (r_st == S_READ) | (r_st == S_SHIFT));
    assign RDWR_B   = 1'b0;
    assign D        = (r_st == S_SHIFT) ? w_d : '0;
    assign nDONELED = (r_st != S_DONE);
    assign nERRLED  = (r_st != S_ERR);
    assign STATE    = (r_st == S_ERR) ? 3'd7 : r_st[2:0];
    assign BYTES    = r_bytes;

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
Next-generation CPLD configuration loader. It pulls a bitstream from the USB FIFO part (nRXF/nRD, 8-bit data) and drives it into the FPGA configuration port. The port is selectable between slave-serial (1-bit) and slave-SelectMAP (8-bit). It adds a programmable CCLK rate, a PROG_B pulse generator, INIT_B/DONE timeouts, CRC-error detection, post-DONE startup clocks and a byte counter.

Parameters:
BUS_WIDTH, 8, FPGA data width; legal values 1 (slave serial) or 8 (SelectMAP).
CCLK_DIV, 2, CK50 cycles per CCLK half-period; minimum 1.
PROG_CYCLES, 64, CK50 cycles PROG_B is held low.
INIT_TIMEOUT, 65535, CK50 cycles to wait for INIT_B high after PROG_B release.
RD_HOLD, 3, CK50 cycles nRD is held low before USB_D is latched.
STARTUP_CLKS, 8, CCLK pulses issued after DONE is seen.
CNT_W, 24, byte counter width.

Ports:
CK50  in  1  50 MHz clock; all logic on rising edge.
nRST  in  1  synchronous active-low reset.
nPROG_REQ  in  1  async active-low reload request (push button); synchronised and edge-detected internally.
nRXF  in  1  USB FIFO not-data-ready; async, 2-flop synchronised.
USB_D  in  8  USB FIFO data, valid RD_HOLD cycles after nRD falls.
nRD  out  1  USB FIFO read strobe, active low.
PROG_B  out  1  FPGA PROG_B; 0 drives low, 1 is released high.
INIT_B  in  1  FPGA INIT_B; async, 2-flop synchronised.
DONE  in  1  FPGA DONE; async, 2-flop synchronised.
CCLK  out  1  configuration clock.
CSI_B  out  1  FPGA chip select, active low.
RDWR_B  out  1  held 0 (write) for the whole block lifetime.
D  out  BUS_WIDTH  configuration data; bit0 is DIN in serial mode.
nDONELED  out  1  low when state==CFG_DONE.
nERRLED  out  1  low when state==ERROR.
STATE  out  3  current state encoding, for debug.
BYTES  out  CNT_W  bytes clocked into the FPGA since the last PROG.

Behaviour:
- Reset values (nRST=0 at a CK50 edge): state=IDLE, nRD=1, PROG_B=1, CCLK=0, CSI_B=1, D=0, BYTES=0, nDONELED=1, nERRLED=1, prescaler=0.
- Synchronisers reset to their inactive levels: nRXF=1, INIT_B=0, DONE=0.
- The prescaler produces a one-cycle tick every CCLK_DIV CK50 cycles. All CCLK edges and nRD edges are aligned to ticks.
- States and encoding:
  - IDLE(0): outputs at reset values. Goes to PROG on a reload request.
  - PROG(1): PROG_B=0 and CSI_B=1 for exactly PROG_CYCLES CK50 cycles. Clears BYTES. Then PROG_B=1 and goes to WAIT_INIT.
  - WAIT_INIT(2): waits for synchronised INIT_B=1, then sets CSI_B=0 and goes to WAIT_DATA. After INIT_TIMEOUT cycles without INIT_B, goes to ERROR.
  - WAIT_DATA(3): if DONE=1, goes to STARTUP. Else, if synchronised nRXF=0, drives nRD=0 and goes to READ.
  - READ(4): nRD held low RD_HOLD cycles, then USB_D latched into the shift register, nRD=1, and goes to SHIFT.
  - SHIFT(5), BUS_WIDTH=8: D=byte; one CCLK pulse (high one half-period, low one half-period).
  - SHIFT(5), BUS_WIDTH=1: 8 CCLK pulses, MSB first. D changes only while CCLK=0 and is stable one full half-period before each rising edge.
  - SHIFT exit: after the last falling edge, BYTES+=1 (saturates at all-ones), then WAIT_DATA.
  - STARTUP(6): CSI_B=1, D=0, STARTUP_CLKS CCLK pulses, then CFG_DONE.
  - CFG_DONE(7): idle outputs except nDONELED=0. Goes to ERROR if DONE drops while INIT_B=0.
  - ERROR: reuses encoding 7, distinguished by nERRLED=0. Outputs idle, PROG_B=1.
- CRC error: synchronised INIT_B=0 in WAIT_DATA, READ or SHIFT goes to ERROR at the next cycle. An in-progress nRD is released (nRD=1) and CCLK is forced to 0.
- Reload request: a falling edge of synchronised nPROG_REQ from any state (including mid-SHIFT) goes to PROG next cycle. CCLK=0, nRD=1, CSI_B=1. The partial byte is discarded and not counted. Holding nPROG_REQ low does not retrigger; it is edge-detected only.
- Simultaneous events: nRST > reload request > INIT_B error > DONE > data_ready.
- nRD is never low while CCLK is high. CCLK has no glitches and a minimum high/low time of CCLK_DIV cycles.
- nRST is sampled only on CK50 edges. Asserting it mid-operation returns every output to its reset value on that edge.

Test Plan:
- Normal SelectMAP load, BUS_WIDTH=8, CCLK_DIV=2: pulse nPROG_REQ; feed bytes A5,3C,FF, then raise DONE. Required: PROG_B low 64 cycles; D=A5,3C,FF on successive CCLK rises; BYTES=3; 8 startup CCLKs; nDONELED=0, STATE=7.
- Serial mode, BUS_WIDTH=1: byte 0xA5. Required: DIN sequence 1,0,1,0,0,1,0,1 on 8 CCLK rises, MSB first; BYTES=1.
- INIT timeout: INIT_B held 0 after PROG, INIT_TIMEOUT=100. Required: ERROR after exactly 100 cycles in WAIT_INIT; nERRLED=0; CCLK never toggled.
- CRC error: INIT_B forced low during the 3rd byte's SHIFT. Required: ERROR next cycle; CCLK=0, nRD=1; BYTES=2.
- Reload mid-byte: nPROG_REQ falls during SHIFT in serial mode, after 4 bits. Required: PROG next cycle; BYTES cleared to 0; a fresh load completes normally.
- Flow control and reset: nRXF held high for 1000 cycles in WAIT_DATA. Required: no nRD or CCLK activity. Then nRST=0 mid-READ. Required: all outputs at reset values on that edge; state=IDLE.
